generador_morse: RTL
====================

// Module: generador_morse
// PURPOSE
//  Sequences one Morse letter (up to 5 dot/dash elements) into a keyed tone-enable.
//  Sits directly upstream of the 28-bit equality comparator in the transmitter.
//  Exports its running time count (cuenta) and the current duration limit (limite) so the
//  comparator can be driven from them. Terminal-count detection is also kept internal.
// PARAMETERS
//  UNIDAD  12_500_000  clock cycles per Morse time unit; 1 <= UNIDAD <= 89_478_485 (3*UNIDAD fits 28b)
// PORTS
//  clk        in   1   system clock, all state changes on rising edge
//  reset      in   1   asynchronous, active-high; clears all state immediately
//  start      in   1   request to send a letter; sampled only when ocupado=0
//  simbolos   in   5   element pattern, bit i = element i (1=dash, 0=dot); bit 0 sent first
//  longitud   in   3   number of elements 1..5; values >5 clamp to 5; 0 = start ignored
//  tono       out  1   key/tone enable, high during marks
//  ocupado    out  1   high while a letter is in progress
//  listo      out  1   one-cycle pulse when the letter (incl. trailing gap) completes
//  cuenta     out  28  cycles elapsed in current state (to comparator entrada2)
//  limite     out  28  duration of current state in cycles (to comparator entrada1)
// BEHAVIOUR
//  Reset: state=IDLE; tono=0, ocupado=0, listo=0, cuenta=0, limite=0; latched pattern/len cleared.
//  States: IDLE, MARCA, ESPACIO, FIN_LETRA. All outputs registered.
//  IDLE: on start=1 and longitud!=0 -> latch simbolos, min(longitud,5); idx=0; next cycle
//   state=MARCA, tono=1, ocupado=1, cuenta=0, limite = simbolos[0] ? 3*UNIDAD : UNIDAD.
//   start with longitud=0: no state change, no listo.
//  Counting: cuenta increments by 1 every cycle in non-IDLE states; state ends on the cycle
//   where cuenta == limite-1, so each state lasts exactly limite cycles; cuenta reset to 0 on exit.
//  MARCA end: if idx == len-1 -> FIN_LETRA (tono=0, limite=3*UNIDAD);
//   else -> ESPACIO (tono=0, limite=UNIDAD).
//  ESPACIO end: idx++ -> MARCA, tono=1, limite per pattern bit idx.
//  FIN_LETRA end: -> IDLE; in that next cycle ocupado=0, listo=1 (exactly one cycle),
//   cuenta=0, limite=0.
//  start while ocupado=1 is ignored (no queueing). start in the same cycle listo=1 is accepted
//   (state IDLE, ocupado=0) -> back-to-back letters with no extra idle cycle.
//  Pattern bits above len-1 are don't-care. Inputs simbolos/longitud are not sampled after start.
//  3*UNIDAD computed at elaboration as a 28-bit constant; no runtime multiply.
//  UNIDAD=1: dot mark 1 cycle, dash 3 cycles; compare cuenta==limite-1 still valid (0==0).
//  Reset asserted mid-letter: immediate return to reset values; tono drops asynchronously;
//   no listo pulse; after release, block idles until a new start.
//  Letter total length = sum(marks) + (len-1)*UNIDAD + 3*UNIDAD cycles; listo one cycle later.
// TESTING
//  UNIDAD=4. 'A': simbolos=5'b00010, longitud=2, start pulse at cycle 0 -> tono=1 cycles 1-4,
//   0 cycles 5-8, 1 cycles 9-20, 0 cycles 21-32; ocupado=1 cycles 1-32; listo=1 only cycle 33.
//  UNIDAD=4. 'E': simbolos=0, longitud=1 -> tono=1 cycles 1-4, 0 cycles 5-16, listo cycle 17;
//   limite=4 cycles 1-4, 12 cycles 5-16; cuenta ramps 0..3 then 0..11.
//  Start pulses during cycles 2 and 10 of letter 'A' -> ignored, waveform identical to test 1.
//  longitud=0 with start -> ocupado, tono, listo stay 0 for 50 cycles; longitud=7, simbolos=5'h1F
//   -> exactly 5 dashes of 12 cycles, gaps of 4, listo at cycle 1+5*12+4*4+12 = 89.
//  Back-to-back: start held high continuously with 'A' -> listo cycle 33, next tono rise cycle 34.
//  Reset asserted at cycle 10 of 'A' -> tono, ocupado, cuenta, limite 0 same cycle; no listo;
//   fresh 'E' after release matches test 2 timing relative to its start.

Source files
------------

// File: rtl/generador_morse.sv
// Morse letter sequencer: plays up to five dot/dash elements as a keyed tone-enable and
// exposes its running count and current duration limit for an external comparator.
module generador_morse #(
   parameter int UNIDAD = 12_500_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  simbolos,
   input  logic [2:0]  longitud,
   output logic        tono,
   output logic        ocupado,
   output logic        listo,
   output logic [27:0] cuenta,
   output logic [27:0] limite
);

   localparam logic [27:0] UNO  = 28'(UNIDAD);
   localparam logic [27:0] TRES = 28'(3 * UNIDAD);

   typedef enum logic [1:0] {
      IDLE,
      MARCA,
      ESPACIO,
      FIN_LETRA
   } estado_t;

   estado_t     estado, estado_d;
   logic [4:0]  patron, patron_d;
   logic [2:0]  len, len_d;
   logic [2:0]  idx, idx_d;
   logic        tono_d, ocupado_d, listo_d;
   logic [27:0] cuenta_d, limite_d;
   logic        fin;
   logic [2:0]  idx_sig;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado  <= IDLE;
         patron  <= '0;
         len     <= '0;
         idx     <= '0;
         tono    <= 1'b0;
         ocupado <= 1'b0;
         listo   <= 1'b0;
         cuenta  <= '0;
         limite  <= '0;
      end else begin
         estado  <= estado_d;
         patron  <= patron_d;
         len     <= len_d;
         idx     <= idx_d;
         tono    <= tono_d;
         ocupado <= ocupado_d;
         listo   <= listo_d;
         cuenta  <= cuenta_d;
         limite  <= limite_d;
      end
   end

   // A state ends on its last cycle, so each state lasts exactly limite cycles.
   assign fin     = (cuenta == limite - 28'd1);
   assign idx_sig = idx + 3'd1;

   always_comb begin
      estado_d  = estado;
      patron_d  = patron;
      len_d     = len;
      idx_d     = idx;
      tono_d    = tono;
      ocupado_d = ocupado;
      listo_d   = 1'b0;
      cuenta_d  = cuenta + 28'd1;
      limite_d  = limite;

      unique case (estado)
         IDLE: begin
            cuenta_d  = '0;
            limite_d  = '0;
            tono_d    = 1'b0;
            ocupado_d = 1'b0;
            if (start && longitud != 3'd0) begin
               patron_d  = simbolos;
               len_d     = (longitud > 3'd5) ? 3'd5 : longitud;
               idx_d     = '0;
               estado_d  = MARCA;
               tono_d    = 1'b1;
               ocupado_d = 1'b1;
               limite_d  = simbolos[0] ? TRES : UNO;
            end
         end
         MARCA: begin
            if (fin) begin
               cuenta_d = '0;
               tono_d   = 1'b0;
               if (idx == len - 3'd1) begin
                  estado_d = FIN_LETRA;
                  limite_d = TRES;
               end else begin
                  estado_d = ESPACIO;
                  limite_d = UNO;
               end
            end
         end
         ESPACIO: begin
            if (fin) begin
               cuenta_d = '0;
               idx_d    = idx_sig;
               estado_d = MARCA;
               tono_d   = 1'b1;
               limite_d = patron[idx_sig] ? TRES : UNO;
            end
         end
         FIN_LETRA: begin
            if (fin) begin
               estado_d  = IDLE;
               cuenta_d  = '0;
               limite_d  = '0;
               tono_d    = 1'b0;
               ocupado_d = 1'b0;
               listo_d   = 1'b1;
            end
         end
         default: estado_d = IDLE;
      endcase
   end

endmodule
